// File: rtl/sr_bank_pkg.sv
// Shared types for the SR flip-flop bank.
//   mode_e      : conflict policy applied when s=r=1 on a channel
//   winner_e    : per-channel last-asserted-wins history state
//   decode_mode : maps the raw 3-bit mode input onto mode_e; 5..7 fold to hold
package sr_bank_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SET  = 3'd1,
    MODE_RST  = 3'd2,
    MODE_TGL  = 3'd3,
    MODE_LAST = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_S    = 2'd1,
    W_R    = 2'd2
  } winner_e;

  function automatic mode_e decode_mode(input logic [2:0] m);
    mode_e res;
    case (m)
      3'd1:    res = MODE_SET;
      3'd2:    res = MODE_RST;
      3'd3:    res = MODE_TGL;
      3'd4:    res = MODE_LAST;
      default: res = MODE_HOLD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One channel of the SR bank: q, edge history (s_prev/r_prev), the
// last-wins winner state and the sticky conflict flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   en                  : update enable for q and winner
//   mode                : conflict policy (raw 3-bit code)
//   s, r                : set / reset request
//   clr_conflict        : clears the sticky flag (beats a same-cycle conflict)
//   q                   : registered state
//   conflict_flag       : sticky s=r=1 (with en) indicator
//   conflict_now        : this cycle's s&r&en, for the bank counter
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       s,
  input  logic       r,
  input  logic       clr_conflict,
  output logic       q,
  output logic       conflict_flag,
  output logic       conflict_now
);

  logic    r_q;
  logic    r_s_prev;
  logic    r_r_prev;
  winner_e r_winner;
  logic    r_flag;

  logic    w_s_rise;
  logic    w_r_rise;
  winner_e w_winner_nxt;
  logic    w_q_nxt;
  mode_e   w_mode;

  always_comb begin
    w_s_rise     = s & ~r_s_prev;
    w_r_rise     = r & ~r_r_prev;
    w_mode       = decode_mode(mode);

    // Simultaneous rising edges cancel out; otherwise the sole active or
    // sole newly-risen input wins. Anything else keeps the old winner.
    w_winner_nxt = r_winner;
    if ((!s && !r) || (w_s_rise && w_r_rise))
      w_winner_nxt = W_NONE;
    else if ((s && !r) || (w_s_rise && !w_r_rise))
      w_winner_nxt = W_S;
    else if ((r && !s) || (w_r_rise && !w_s_rise))
      w_winner_nxt = W_R;

    w_q_nxt = r_q;
    case ({s, r})
      2'b01: w_q_nxt = 1'b0;
      2'b10: w_q_nxt = 1'b1;
      2'b11: begin
        case (w_mode)
          MODE_SET: w_q_nxt = 1'b1;
          MODE_RST: w_q_nxt = 1'b0;
          MODE_TGL: w_q_nxt = ~r_q;
          MODE_LAST: begin
            if (w_winner_nxt == W_S)
              w_q_nxt = 1'b1;
            else if (w_winner_nxt == W_R)
              w_q_nxt = 1'b0;
          end
          default: w_q_nxt = r_q;
        endcase
      end
      default: w_q_nxt = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= RST_BIT;
      r_s_prev <= 1'b0;
      r_r_prev <= 1'b0;
      r_winner <= W_NONE;
      r_flag   <= 1'b0;
    end else begin
      // Edge history tracks the inputs even while updates are disabled.
      r_s_prev <= s;
      r_r_prev <= r;
      if (en) begin
        r_q      <= w_q_nxt;
        r_winner <= w_winner_nxt;
      end
      if (clr_conflict)
        r_flag <= 1'b0;
      else if (conflict_now)
        r_flag <= 1'b1;
    end
  end

  assign conflict_now  = en & s & r;
  assign q             = r_q;
  assign conflict_flag = r_flag;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent edge-triggered SR flip-flops with a selectable
// S=R=1 policy, sticky per-channel conflict flags and a saturating count of
// enabled cycles in which any channel conflicted.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en             : update enable
//   mode           : 0 hold, 1 set-dom, 2 reset-dom, 3 toggle, 4 last-wins
//   s, r           : per-channel set / reset
//   clr_conflict   : clears conflict_flag and conflict_cnt
//   q, qbar        : registered state and its complement
//   conflict_flag  : per-channel sticky conflict indicator
//   conflict_cnt   : saturating conflict-cycle counter
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict_flag,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_conflict_now;
  logic             w_any_conflict;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    sr_cell #(
      .RST_BIT (RST_VAL[g])
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .mode          (mode),
      .s             (s[g]),
      .r             (r[g]),
      .clr_conflict  (clr_conflict),
      .q             (q[g]),
      .conflict_flag (conflict_flag[g]),
      .conflict_now  (w_conflict_now[g])
    );
  end

  assign w_any_conflict = |w_conflict_now;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (clr_conflict)
      r_cnt <= '0;
    else if (w_any_conflict && (r_cnt != CNT_MAX))
      r_cnt <= r_cnt + CNT_ONE;
  end

  assign conflict_cnt = r_cnt;
  assign qbar         = ~q;

endmodule

// File: tb/tb_sr_ff_bank.sv
module tb_sr_ff_bank;

  localparam int          WIDTH   = 8;
  localparam int          CNT_W   = 2;
  localparam logic [7:0]  RST_VAL = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_conflict;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] conflict_flag;
  logic [CNT_W-1:0] conflict_cnt;

  int tests = 0;
  int fails = 0;

  sr_ff_bank #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .mode          (mode),
    .s             (s),
    .r             (r),
    .clr_conflict  (clr_conflict),
    .q             (q),
    .qbar          (qbar),
    .conflict_flag (conflict_flag),
    .conflict_cnt  (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Apply inputs on the falling edge, clock once, sample 1 time unit later.
  task automatic cyc(input logic i_rst, input logic i_en, input logic [2:0] i_mode,
                     input logic [7:0] i_s, input logic [7:0] i_r, input logic i_clr);
    @(negedge clk);
    rst = i_rst; en = i_en; mode = i_mode; s = i_s; r = i_r; clr_conflict = i_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; s = '0; r = '0; clr_conflict = 1'b0;

    // Reset
    cyc(1, 0, 3'd0, 8'h00, 8'h00, 0);
    check("rst_q",    {24'd0, q},             32'hA5);
    check("rst_qbar", {24'd0, qbar},          32'h5A);
    check("rst_cnt",  {30'd0, conflict_cnt},  32'h0);
    check("rst_flag", {24'd0, conflict_flag}, 32'h0);

    // Basic set/clear
    cyc(0, 1, 3'd0, 8'h0F, 8'hF0, 0);
    check("basic_q",    {24'd0, q},    32'h0F);
    check("basic_qbar", {24'd0, qbar}, 32'hF0);
    check("basic_cnt",  {30'd0, conflict_cnt}, 32'h0);

    // Policy sweep, s=r=FF for 3 cycles from q=0F
    cyc(0, 1, 3'd0, 8'hFF, 8'hFF, 0);
    check("hold_c1", {24'd0, q}, 32'h0F);
    check("hold_flag", {24'd0, conflict_flag}, 32'hFF);
    check("hold_cnt1", {30'd0, conflict_cnt}, 32'h1);
    cyc(0, 1, 3'd0, 8'hFF, 8'hFF, 0);
    cyc(0, 1, 3'd0, 8'hFF, 8'hFF, 0);
    check("hold_c3", {24'd0, q}, 32'h0F);

    cyc(0, 1, 3'd0, 8'h0F, 8'hF0, 0);
    cyc(0, 1, 3'd1, 8'hFF, 8'hFF, 0);
    check("setdom_c1", {24'd0, q}, 32'hFF);
    cyc(0, 1, 3'd1, 8'hFF, 8'hFF, 0);
    cyc(0, 1, 3'd1, 8'hFF, 8'hFF, 0);
    check("setdom_c3", {24'd0, q}, 32'hFF);

    cyc(0, 1, 3'd0, 8'h0F, 8'hF0, 0);
    cyc(0, 1, 3'd2, 8'hFF, 8'hFF, 0);
    check("rstdom_c1", {24'd0, q}, 32'h00);
    cyc(0, 1, 3'd2, 8'hFF, 8'hFF, 0);
    cyc(0, 1, 3'd2, 8'hFF, 8'hFF, 0);
    check("rstdom_c3", {24'd0, q}, 32'h00);

    cyc(0, 1, 3'd0, 8'h0F, 8'hF0, 0);
    cyc(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("tgl_c1", {24'd0, q}, 32'hF0);
    cyc(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("tgl_c2", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("tgl_c3", {24'd0, q}, 32'hF0);
    check("tgl_qbar", {24'd0, qbar}, 32'h0F);

    cyc(0, 1, 3'd0, 8'h0F, 8'hF0, 0);
    cyc(0, 1, 3'd6, 8'hFF, 8'hFF, 0);
    check("mode6_c1", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd6, 8'hFF, 8'hFF, 0);
    cyc(0, 1, 3'd6, 8'hFF, 8'hFF, 0);
    check("mode6_c3", {24'd0, q}, 32'h0F);
    check("cnt_sat_sweep", {30'd0, conflict_cnt}, 32'h3);

    // Last-wins on channel 0
    cyc(0, 1, 3'd4, 8'h00, 8'h00, 0);
    check("lw_idle", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd4, 8'h00, 8'h01, 0);
    check("lw_r", {24'd0, q}, 32'h0E);
    cyc(0, 1, 3'd4, 8'h01, 8'h01, 0);
    check("lw_s_rise", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd4, 8'h01, 8'h00, 0);
    check("lw_r_drop", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd4, 8'h01, 8'h01, 0);
    check("lw_r_rerise", {24'd0, q}, 32'h0E);
    cyc(0, 1, 3'd4, 8'h01, 8'h00, 0);
    cyc(0, 1, 3'd4, 8'h00, 8'h00, 0);
    check("lw_pre_both", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd4, 8'h01, 8'h01, 0);
    check("lw_both_rise", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd4, 8'h01, 8'h01, 0);
    check("lw_both_persist", {24'd0, q}, 32'h0F);

    // Enable gating
    cyc(0, 0, 3'd4, 8'h00, 8'h00, 1);
    check("clr_cnt", {30'd0, conflict_cnt}, 32'h0);
    check("clr_flag", {24'd0, conflict_flag}, 32'h0);
    cyc(0, 0, 3'd4, 8'hFF, 8'h00, 0);
    check("en0_q", {24'd0, q}, 32'h0F);
    cyc(0, 1, 3'd4, 8'hFF, 8'h00, 0);
    check("en1_set", {24'd0, q}, 32'hFF);
    cyc(0, 0, 3'd4, 8'hFF, 8'hFF, 0);
    check("en0_conf_q", {24'd0, q}, 32'hFF);
    check("en0_conf_cnt", {30'd0, conflict_cnt}, 32'h0);
    check("en0_conf_flag", {24'd0, conflict_flag}, 32'h0);
    cyc(0, 1, 3'd4, 8'hFF, 8'hFF, 0);
    check("en_hist_q", {24'd0, q}, 32'hFF);
    check("en_hist_cnt", {30'd0, conflict_cnt}, 32'h1);

    // Conflict counter saturation (CNT_W=2)
    cyc(0, 0, 3'd0, 8'h00, 8'h00, 1);
    check("cnt_clr", {30'd0, conflict_cnt}, 32'h0);
    cyc(0, 1, 3'd0, 8'h81, 8'hC3, 0);
    check("cnt_1", {30'd0, conflict_cnt}, 32'h1);
    check("cnt_q", {24'd0, q}, 32'hBD);
    cyc(0, 1, 3'd0, 8'h81, 8'hC3, 0);
    cyc(0, 1, 3'd0, 8'h81, 8'hC3, 0);
    check("cnt_3", {30'd0, conflict_cnt}, 32'h3);
    cyc(0, 1, 3'd0, 8'h81, 8'hC3, 0);
    cyc(0, 1, 3'd0, 8'h81, 8'hC3, 0);
    check("cnt_sat", {30'd0, conflict_cnt}, 32'h3);
    check("cnt_flags", {24'd0, conflict_flag}, 32'h81);
    cyc(0, 1, 3'd0, 8'hFF, 8'hFF, 1);
    check("clr_prio_cnt", {30'd0, conflict_cnt}, 32'h0);
    check("clr_prio_flag", {24'd0, conflict_flag}, 32'h0);
    cyc(0, 1, 3'd0, 8'h0F, 8'hF0, 0);
    check("noconf_cnt", {30'd0, conflict_cnt}, 32'h0);
    check("noconf_q", {24'd0, q}, 32'h0F);

    // Synchronous reset mid-toggle
    cyc(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("pre_rst_tgl", {24'd0, q}, 32'hF0);
    cyc(1, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("midrst_q", {24'd0, q}, 32'hA5);
    check("midrst_cnt", {30'd0, conflict_cnt}, 32'h0);
    check("midrst_flag", {24'd0, conflict_flag}, 32'h0);
    cyc(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("post_rst_t1", {24'd0, q}, 32'h5A);
    cyc(0, 1, 3'd3, 8'hFF, 8'hFF, 0);
    check("post_rst_t2", {24'd0, q}, 32'hA5);
    check("post_rst_cnt", {30'd0, conflict_cnt}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
